regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single write port of the 8x8 register file between two writeback
//  requesters: req0 (ALU) and req1 (load unit).
//  Each requester has a one-entry holding buffer with a valid/ready handshake.
//  Writes are granted oldest-first, and ties are broken round-robin.
//  A pending-write scoreboard lets decode stall on registers not yet written.
// PARAMETERS
//  DATA_W  8  width of write data
//  ADDR_W  3  width of register address (2**ADDR_W registers)
// PORTS
//  clk          in   1       single clock, all state updates on posedge
//  reset        in   1       synchronous, active-high reset
//  req0_valid   in   1       requester 0 offers a write
//  req0_dest    in   ADDR_W  requester 0 destination register
//  req0_data    in   DATA_W  requester 0 write data
//  req0_ready   out  1       requester 0 buffer can accept this cycle
//  req1_valid   in   1       requester 1 offers a write
//  req1_dest    in   ADDR_W  requester 1 destination register
//  req1_data    in   DATA_W  requester 1 write data
//  req1_ready   out  1       requester 1 buffer can accept this cycle
//  rf_writeEn   out  1       to register file writeEn
//  rf_dest      out  ADDR_W  to register file dest
//  rf_data      out  DATA_W  to register file data
//  pending      out  2**ADDR_W  bit d=1 while any buffer holds a write to reg d
//  busy         out  1       either buffer full
// BEHAVIOUR
//  State per buffer i: full_i, dest_i, data_i. Shared state: older (which buffer
//   was loaded first, valid when both full), rr (tie-break pointer).
//  Reset (sync): full_0=full_1=0, older=0, rr=0.
//   While reset=1: readyN=0, rf_writeEn=0.
//   All outputs 0 in the cycle after reset.
//   Buffered writes are discarded, including a write mid-arbitration.
//  Handshake: reqN_ready = !reset && (!full_N || grant_N).
//   A transfer occurs on a posedge where valid && ready.
//   The buffer loads dest/data and sets full_N on that edge.
//   valid may drop without a transfer; the block holds no requester state.
//  Grant (combinational from registered state):
//   - Only one buffer full: grant it.
//   - Both full, loaded on different edges: grant the older one.
//   - Both full, loaded on the same edge: grant rr; rr toggles on that edge.
//   - Neither full: no grant.
//  rf_writeEn = any grant. rf_dest/rf_data = granted buffer contents;
//   0 when no grant. The register file commits at the same edge that clears
//   the granted buffer.
//  Latency: accept at edge N; earliest register-file write at edge N+1.
//   One write per cycle maximum.
//   Sustained throughput is 1 write/cycle total, shared between requesters.
//  Simultaneous drain and refill of the same buffer: the refill is newer than
//   the other full buffer.
//  Same-dest writes: the oldest-first rule preserves acceptance order across
//   requesters. Same-edge acceptance of the same dest commits req order via rr.
//   Callers must not rely on that ordering.
//  pending[d] = (full_0 && dest_0==d) || (full_1 && dest_1==d); pure function
//   of registered state, no bypass of inputs.
//  busy = full_0 || full_1.
// TESTING
//  1. Reset, then req0 valid dest=3 data=8'hA5 for one cycle:
//     next cycle rf_writeEn=1, rf_dest=3, rf_data=A5, pending=8'h08;
//     the following cycle pending=0.
//  2. req0 (dest1,11) and req1 (dest2,22) both accepted on one edge:
//     writes on consecutive cycles, req0 first (rr=0);
//     repeat the case and req1 goes first.
//  3. req1 (dest5,55) accepted, then req0 (dest5,66) one cycle later while req1
//     is still held: reg5 written 55 then 66, and pending[5] stays set across
//     both cycles.
//  4. Both requesters hold valid every cycle for 20 cycles:
//     rf_writeEn=1 every cycle after the first, grants alternate 0/1,
//     and neither ready is low for more than 1 cycle.
//  5. Assert reset while both buffers are full:
//     no rf_writeEn during or after reset, pending=0, busy=0,
//     and readys are 0 during the reset cycle.
//  6. req0 valid with no transfer (buffer full, no grant) for 3 cycles while
//     data changes: only the data present on the accepting edge is written.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between two writeback requesters,
// each with a one-entry holding buffer; oldest-first grant, round-robin tie-break.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_dest,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_dest,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    output logic                     rf_writeEn,
    output logic [ADDR_W-1:0]        rf_dest,
    output logic [DATA_W-1:0]        rf_data,
    output logic [(1<<ADDR_W)-1:0]   pending,
    output logic                     busy
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic              full0_q, full1_q;
    logic [ADDR_W-1:0] dest0_q, dest1_q;
    logic [DATA_W-1:0] data0_q, data1_q;
    logic              older_q;  // 1: buffer 1 was loaded before buffer 0
    logic              same_q;   // both buffers were loaded on the same edge
    logic              rr_q;
    logic              grant0, grant1;
    logic              load0, load1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0_q && full1_q) begin
            if (same_q) begin
                grant0 = !rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = !older_q;
                grant1 = older_q;
            end
        end else begin
            grant0 = full0_q;
            grant1 = full1_q;
        end
    end

    assign req0_ready = !reset && (!full0_q || grant0);
    assign req1_ready = !reset && (!full1_q || grant1);
    assign load0      = req0_valid && req0_ready;
    assign load1      = req1_valid && req1_ready;

    assign rf_writeEn = !reset && (grant0 || grant1);
    assign rf_dest    = !rf_writeEn ? '0 : (grant1 ? dest1_q : dest0_q);
    assign rf_data    = !rf_writeEn ? '0 : (grant1 ? data1_q : data0_q);
    assign busy       = full0_q || full1_q;

    always_comb begin
        pending = '0;
        for (int unsigned d = 0; d < NREG; d++) begin
            pending[d] = (full0_q && dest0_q == ADDR_W'(d)) ||
                         (full1_q && dest1_q == ADDR_W'(d));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            dest0_q <= '0;
            dest1_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
            older_q <= 1'b0;
            same_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            full0_q <= load0 || (full0_q && !grant0);
            full1_q <= load1 || (full1_q && !grant1);
            if (load0) begin
                dest0_q <= req0_dest;
                data0_q <= req0_data;
            end
            if (load1) begin
                dest1_q <= req1_dest;
                data1_q <= req1_data;
            end
            // A refill is always newer than whatever the other buffer holds.
            if (load0 && load1) begin
                same_q <= 1'b1;
            end else if (load0) begin
                same_q  <= 1'b0;
                older_q <= 1'b1;
            end else if (load1) begin
                same_q  <= 1'b0;
                older_q <= 1'b0;
            end
            if (full0_q && full1_q && same_q) begin
                rr_q <= !rr_q;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_dest, req1_dest;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       rf_writeEn;
    logic [2:0] rf_dest;
    logic [7:0] rf_data;
    logic [7:0] pending;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_dest  (req0_dest),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dest  (req1_dest),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_writeEn (rf_writeEn),
        .rf_dest    (rf_dest),
        .rf_data    (rf_data),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
        req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
        step();
        n_checks++;
        if ({req0_ready, req1_ready, rf_writeEn} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: ready0/ready1/wen=%b required 000",
                     {req0_ready, req1_ready, rf_writeEn});
        end
        reset = 1'b0;
        step();
        n_checks++;
        if ({rf_writeEn, rf_dest, rf_data, pending, busy} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_after: wen=%b dest=%0d data=%h pend=%h busy=%b required all 0",
                     rf_writeEn, rf_dest, rf_data, pending, busy);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_dest = 3'd3; req0_data = 8'hA5;
        step();
        req0_valid = 1'b0;
        n_checks++;
        if ({rf_writeEn, rf_dest, rf_data, pending} !== {1'b1, 3'd3, 8'hA5, 8'h08}) begin
            n_fail++;
            $display("FAIL single_write: wen=%b dest=%0d data=%h pend=%h required 1 3 a5 08",
                     rf_writeEn, rf_dest, rf_data, pending);
        end
        step();
        n_checks++;
        if ({rf_writeEn, pending} !== 9'd0) begin
            n_fail++;
            $display("FAIL single_drain: wen=%b pend=%h required 0 00", rf_writeEn, pending);
        end
    endtask

    task automatic test_tie();
        for (int rep = 0; rep < 2; rep++) begin
            req0_valid = 1'b1; req0_dest = 3'd1; req0_data = 8'h11;
            req1_valid = 1'b1; req1_dest = 3'd2; req1_data = 8'h22;
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            n_checks++;
            if (pending !== 8'h06) begin
                n_fail++;
                $display("FAIL tie_pending rep%0d: pend=%h required 06", rep, pending);
            end
            n_checks++;
            if ({rf_writeEn, rf_dest, rf_data} !==
                ((rep == 0) ? {1'b1, 3'd1, 8'h11} : {1'b1, 3'd2, 8'h22})) begin
                n_fail++;
                $display("FAIL tie_first rep%0d: wen=%b dest=%0d data=%h", rep,
                         rf_writeEn, rf_dest, rf_data);
            end
            step();
            n_checks++;
            if ({rf_writeEn, rf_dest, rf_data} !==
                ((rep == 0) ? {1'b1, 3'd2, 8'h22} : {1'b1, 3'd1, 8'h11})) begin
                n_fail++;
                $display("FAIL tie_second rep%0d: wen=%b dest=%0d data=%h", rep,
                         rf_writeEn, rf_dest, rf_data);
            end
            step();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL tie_idle rep%0d: busy=%b required 0", rep, busy);
            end
        end
    endtask

    task automatic test_same_dest();
        req1_valid = 1'b1; req1_dest = 3'd5; req1_data = 8'h55;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_dest = 3'd5; req0_data = 8'h66;
        n_checks++;
        if ({rf_writeEn, rf_dest, rf_data, pending[5]} !== {1'b1, 3'd5, 8'h55, 1'b1}) begin
            n_fail++;
            $display("FAIL samedest_first: wen=%b dest=%0d data=%h pend5=%b required 1 5 55 1",
                     rf_writeEn, rf_dest, rf_data, pending[5]);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if ({rf_writeEn, rf_dest, rf_data, pending[5]} !== {1'b1, 3'd5, 8'h66, 1'b1}) begin
            n_fail++;
            $display("FAIL samedest_second: wen=%b dest=%0d data=%h pend5=%b required 1 5 66 1",
                     rf_writeEn, rf_dest, rf_data, pending[5]);
        end
        step();
        n_checks++;
        if (pending !== 8'h00) begin
            n_fail++;
            $display("FAIL samedest_clear: pend=%h required 00", pending);
        end
    endtask

    task automatic test_back_to_back();
        int low0 = 0;
        int low1 = 0;
        req0_valid = 1'b1; req0_dest = 3'd0; req0_data = 8'h00;
        req1_valid = 1'b1; req1_dest = 3'd7; req1_data = 8'h80;
        for (int k = 1; k <= 20; k++) begin
            step();
            req0_data = 8'(k);
            req1_data = 8'(8'h80 + k);
            n_checks++;
            if ({rf_writeEn, rf_dest} !== {1'b1, ((k % 2) == 1) ? 3'd0 : 3'd7}) begin
                n_fail++;
                $display("FAIL b2b_grant cycle%0d: wen=%b dest=%0d", k, rf_writeEn, rf_dest);
            end
            low0 = req0_ready ? 0 : low0 + 1;
            low1 = req1_ready ? 0 : low1 + 1;
            n_checks++;
            if (low0 > 1 || low1 > 1) begin
                n_fail++;
                $display("FAIL b2b_ready cycle%0d: low run0=%0d run1=%0d required <=1",
                         k, low0, low1);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_full();
        req0_valid = 1'b1; req0_dest = 3'd3; req0_data = 8'h33;
        req1_valid = 1'b1; req1_dest = 3'd4; req1_data = 8'h44;
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_checks++;
        if ({pending, busy} !== {8'h18, 1'b1}) begin
            n_fail++;
            $display("FAIL rstfull_loaded: pend=%h busy=%b required 18 1", pending, busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready, rf_writeEn} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstfull_during: ready0/ready1/wen=%b required 000",
                     {req0_ready, req1_ready, rf_writeEn});
        end
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rf_writeEn, pending, busy} !== 10'd0) begin
            n_fail++;
            $display("FAIL rstfull_after: wen=%b pend=%h busy=%b required 0 00 0",
                     rf_writeEn, pending, busy);
        end
        step();
        n_checks++;
        if (rf_writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL rstfull_later: wen=%b required 0", rf_writeEn);
        end
    endtask

    task automatic test_no_transfer();
        // Requests offered during reset are never taken.
        reset = 1'b1;
        req0_valid = 1'b1; req0_dest = 3'd4;
        for (int k = 1; k <= 3; k++) begin
            req0_data = 8'(k);
            #1;
            n_checks++;
            if ({req0_ready, rf_writeEn} !== 2'b00) begin
                n_fail++;
                $display("FAIL notx_reset cycle%0d: ready0=%b wen=%b required 0 0",
                         k, req0_ready, rf_writeEn);
            end
            step();
        end
        reset = 1'b0;
        req0_data = 8'h44;
        step();
        req0_valid = 1'b0;
        n_checks++;
        if ({rf_writeEn, rf_dest, rf_data} !== {1'b1, 3'd4, 8'h44}) begin
            n_fail++;
            $display("FAIL notx_accept: wen=%b dest=%0d data=%h required 1 4 44",
                     rf_writeEn, rf_dest, rf_data);
        end
        step();
        // Buffer 0 full but not granted: changing data is ignored until ready.
        req0_valid = 1'b1; req0_dest = 3'd2; req0_data = 8'h20;
        req1_valid = 1'b1; req1_dest = 3'd6; req1_data = 8'h60;
        step();
        req1_valid = 1'b0;
        req0_data = 8'h21;
        n_checks++;
        if ({rf_dest, rf_data} !== {3'd2, 8'h20}) begin
            n_fail++;
            $display("FAIL notx_w1: dest=%0d data=%h required 2 20", rf_dest, rf_data);
        end
        step();
        req0_data = 8'h22;
        n_checks++;
        if ({req0_ready, rf_dest, rf_data} !== {1'b0, 3'd6, 8'h60}) begin
            n_fail++;
            $display("FAIL notx_w2: ready0=%b dest=%0d data=%h required 0 6 60",
                     req0_ready, rf_dest, rf_data);
        end
        step();
        req0_data = 8'h23;
        n_checks++;
        if ({req0_ready, rf_dest, rf_data} !== {1'b1, 3'd2, 8'h21}) begin
            n_fail++;
            $display("FAIL notx_w3: ready0=%b dest=%0d data=%h required 1 2 21",
                     req0_ready, rf_dest, rf_data);
        end
        step();
        req0_valid = 1'b0;
        n_checks++;
        if ({rf_writeEn, rf_dest, rf_data} !== {1'b1, 3'd2, 8'h23}) begin
            n_fail++;
            $display("FAIL notx_w4: wen=%b dest=%0d data=%h required 1 2 23",
                     rf_writeEn, rf_dest, rf_data);
        end
        step();
        n_checks++;
        if ({rf_writeEn, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL notx_idle: wen=%b busy=%b required 0 0", rf_writeEn, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_same_dest();
        test_back_to_back();
        test_reset_full();
        test_no_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
